// File: rtl/des_decryption_iterative.sv
// Iterative DES core, one Feistel round per cycle, keys K16..K1 by default.
// Build option DES_DEC_KEYLATCH_EN: latch round_keys on the accepted start.
module des_decryption_iterative #(
  parameter int REVERSE_KEYS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [63:0]  ciphertext,
  input  logic [767:0] round_keys,
  output logic         busy,
  output logic         done,
  output logic [63:0]  result
);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int IPI_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each box packs its 4x16 table row-major, entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++)
      o = {o[62:0], x[6'(64 - IP_T[6'(i)])]};
    return o;
  endfunction

  function automatic logic [63:0] ip_inv(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++)
      o = {o[62:0], x[6'(64 - IPI_T[6'(i)])]};
    return o;
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] x);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++)
      o = {o[46:0], x[5'(32 - E_T[6'(i)])]};
    return o;
  endfunction

  function automatic logic [31:0] pperm(input logic [31:0] x);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++)
      o = {o[30:0], x[5'(32 - P_T[5'(i)])]};
    return o;
  endfunction

  function automatic logic [31:0] f(
    input logic [31:0] r,
    input logic [47:0] k
  );
    logic [47:0]  x;
    logic [5:0]   b;
    logic [255:0] row;
    logic [31:0]  s;
    x = expand(r) ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      b   = x[47:42];
      x   = x << 6;
      row = SBOX[3'(j)] << (4 * {b[5], b[0], b[4:1]});
      s   = {s[27:0], row[255:252]};
    end
    return pperm(s);
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q;
  logic [3:0]   kidx;
  logic [31:0]  l_q, r_q, l_d, r_d;
  logic [47:0]  k_cur;
  logic [767:0] keys;
  logic [47:0]  kset [16];
  logic         accept;

  assign accept = (state_q == IDLE) && start;

`ifdef DES_DEC_KEYLATCH_EN
  logic [767:0] key_q;

  always_ff @(posedge clk) begin
    if (accept) key_q <= round_keys;
  end

  assign keys = key_q;
`else
  assign keys = round_keys;
`endif

  for (genvar n = 0; n < 16; n++) begin : g_kset
    assign kset[n] = keys[767-48*n -: 48];
  end

  assign kidx  = (REVERSE_KEYS != 0) ? 4'd15 - cnt_q : cnt_q;
  assign k_cur = kset[kidx];
  assign l_d   = r_q;
  assign r_d   = l_q ^ f(r_q, k_cur);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ROUND;
      ROUND:   if (cnt_q == 4'd15) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        {l_q, r_q} <= ip(ciphertext);
        cnt_q      <= '0;
      end else if (state_q == ROUND) begin
        l_q   <= l_d;
        r_q   <= r_d;
        cnt_q <= cnt_q + 4'd1;
        // Last round: undo the swap before the final permutation.
        if (cnt_q == 4'd15) result <= ip_inv({r_d, l_d});
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
